// File: rtl/regfile_mp.sv
// Multi-ported register file with a power-up clear sequence, write-to-read bypass
// and a per-register pending (scoreboard) bitmap.
//
// After reset the array is walked one entry per cycle and written with zero. While
// that walk runs, busy is high, writes and reservations are ignored, and the read
// ports return zero with no pending flags. Once the walk finishes the file accepts
// NWR writes per cycle. When several ports write the same address, the
// highest-index port wins. wr_collide reports such a collision one cycle later.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   wr_en      [NWR]          per-port write enable
//   wr_addr    [NWR*AW]       packed write addresses, port k in slice k
//   wr_data    [NWR*DATA_W]   packed write data
//   rd_addr    [NRD*AW]       packed read addresses
//   rd_data    [NRD*DATA_W]   packed read data (combinational)
//   rsv_en     reserve rsv_addr (mark pending)
//   rsv_addr   [AW]           register to reserve
//   rd_pend    [NRD]          pending flag of each read address (combinational)
//   busy       high while the clear walk runs (registered)
//   wr_collide one-cycle pulse after a same-address multi-port write (registered)
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic [NRD-1:0]        rd_pend,
  output logic                  busy,
  output logic                  wr_collide
);

  localparam logic StClear = 1'b0;
  localparam logic StReady = 1'b1;

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  logic              state_q, state_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;
  logic              busy_q;
  logic              wr_collide_q, wr_collide_d;
  logic [DEPTH-1:0]  pend_q, pend_d;

  // No reset on the array so it can map onto RAM; the clear walk zeroes it instead.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              collide;
  logic              rsv_ok;
  logic [AW-1:0]     wa [NWR];
  logic [DATA_W-1:0] wd [NWR];
  logic [NWR-1:0]    we_eff;

  logic [AW-1:0]     rd_a;
  logic [DATA_W-1:0] rd_val;
  logic              rd_hit;

  assign ready = (state_q == StReady);

  // Unpack write ports and qualify enables. An address-0 write with ZERO_REG set is
  // treated as if it never happened: no store, no bypass, no collision.
  for (genvar k = 0; k < NWR; k++) begin : gen_wr_unpack
    assign wa[k]     = wr_addr[k*AW +: AW];
    assign wd[k]     = wr_data[k*DATA_W +: DATA_W];
    assign we_eff[k] = ready & wr_en[k] & ~(ZERO_REG & (wr_addr[k*AW +: AW] == '0));
  end

  assign rsv_ok = ready & rsv_en & ~(ZERO_REG & (rsv_addr == '0));

  // Any pair of surviving writes aimed at the same address.
  always_comb begin
    collide = 1'b0;
    for (int unsigned i = 0; i < NWR; i++) begin
      for (int unsigned j = i + 1; j < NWR; j++) begin
        if (we_eff[i] && we_eff[j] && (wa[i] == wa[j])) begin
          collide = 1'b1;
        end
      end
    end
  end

  // Clear walk / ready sequencing. rst pins the walk at entry 0.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == StClear) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LastIdx) begin
        state_d = StReady;
      end
    end
    if (rst) begin
      state_d   = StClear;
      clr_idx_d = '0;
    end
  end

  // Pending bitmap: writes clear, a reservation applied afterwards so it wins a tie.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (we_eff[k]) begin
        pend_d[wa[k]] = 1'b0;
      end
    end
    if (rsv_ok) begin
      pend_d[rsv_addr] = 1'b1;
    end
    if (rst) begin
      pend_d = '0;
    end
  end

  assign wr_collide_d = collide & ~rst;

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    clr_idx_q    <= clr_idx_d;
    busy_q       <= (state_d == StClear);
    wr_collide_q <= wr_collide_d;
    pend_q       <= pend_d;
  end

  // Array write. Ascending port order makes the highest-index port the last
  // assignment, so it wins a same-address tie.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_idx_q] <= '0;
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (we_eff[k]) begin
          mem[wa[k]] <= wd[k];
        end
      end
    end
  end

  // Read ports with optional bypass from this cycle's writes.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    rd_a    = '0;
    rd_val  = '0;
    rd_hit  = 1'b0;
    for (int unsigned j = 0; j < NRD; j++) begin
      rd_a   = rd_addr[j*AW +: AW];
      rd_val = mem[rd_a];
      rd_hit = 1'b0;
      if (BYPASS) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (we_eff[k] && (wa[k] == rd_a)) begin
            rd_val = wd[k];
            rd_hit = 1'b1;
          end
        end
      end
      if (!ready || (ZERO_REG && (rd_a == '0))) begin
        rd_val = '0;
      end
      rd_data[j*DATA_W +: DATA_W] = rd_val;
      rd_pend[j]                  = ready & pend_q[rd_a] & ~rd_hit;
    end
  end

  assign busy       = busy_q;
  assign wr_collide = wr_collide_q;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter DEPTH, default 32, SHALL set the number of registers (power of two, >= 4).
REQ-003 Parameter NRD, default 2, SHALL set the number of read ports.
REQ-004 Parameter NWR, default 2, SHALL set the number of write ports.
REQ-005 Parameter ZERO_REG, default 1, SHALL hardwire register 0 to zero when 1.
REQ-006 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-007 Localparam AW SHALL equal $clog2(DEPTH).
REQ-008 clk  in  1  clock; all state updates on the rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 wr_en  in  NWR  per-port write enable.
REQ-011 wr_addr  in  NWR*AW  packed write addresses; port k uses slice k.
REQ-012 wr_data  in  NWR*DATA_W  packed write data.
REQ-013 rd_addr  in  NRD*AW  packed read addresses.
REQ-014 rd_data  out  NRD*DATA_W  packed read data, combinational.
REQ-015 rsv_en  in  1  reserve a destination register (marks it pending).
REQ-016 rsv_addr  in  AW  register to reserve.
REQ-017 rd_pend  out  NRD  per-read-port pending flag, combinational.
REQ-018 busy  out  1  registered; high while the clear sequence runs.
REQ-019 wr_collide  out  1  registered; pulses one cycle after a same-address multi-port write.

Function
REQ-020 FSM SHALL have two states: CLEAR and READY.
REQ-021 In CLEAR, a counter clr_idx SHALL write zero to entry clr_idx each cycle and increment; on reaching DEPTH-1, the FSM SHALL go to READY.
REQ-022 While rst is high, clr_idx SHALL be held at 0 and the FSM SHALL stay in CLEAR; reset asserted mid-clear restarts at entry 0.
REQ-023 busy SHALL be high in CLEAR and low in READY; after rst deasserts, busy SHALL remain high for exactly DEPTH cycles.
REQ-024 In CLEAR, all wr_en and rsv_en SHALL be ignored, rd_data SHALL read 0, and rd_pend SHALL read 0.
REQ-025 In READY, each port with wr_en[k]=1 SHALL write wr_data[k] to wr_addr[k] at the clock edge.
REQ-026 When several enabled ports target the same address, the highest-index port SHALL win.
REQ-027 wr_collide SHALL be 1 in the cycle after any such same-address collision in READY, else 0.
REQ-028 With ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, reservations of address 0 SHALL be ignored, and address-0 writes SHALL NOT count as collisions.
REQ-029 With BYPASS=1, a read port whose address matches an enabled write port SHALL return that port's wr_data (highest index wins); otherwise it SHALL return stored contents.
REQ-030 With BYPASS=0, reads SHALL return the contents stored before the edge.
REQ-031 The pending bitmap pend[DEPTH] SHALL set pend[rsv_addr] when rsv_en=1 and clear pend[a] when any enabled write port targets a.
REQ-032 Simultaneous reserve and write to the same address SHALL leave pend set (reserve wins).
REQ-033 rd_pend[j] SHALL equal pend[rd_addr[j]], masked to 0 when BYPASS=1 and a write to that address is enabled this cycle.
REQ-034 Registers 1..DEPTH-1 SHALL be RAM-inferable: no single-cycle whole-array reset.

Reset
REQ-035 At rst, busy SHALL go to 1, wr_collide to 0, pend to all zeros, FSM to CLEAR, and clr_idx to 0 at the next edge.
REQ-036 After the clear sequence, every register SHALL read 0.

Verification (DATA_W=32, DEPTH=32, NRD=2, NWR=2, ZERO_REG=1, BYPASS=1)
REQ-037 rst for 1 cycle, then count the cycles where busy=1 -> exactly 32; rd_data reads 0 throughout; a write during busy is lost.
REQ-038 Port0 writes r5=0x11 and port1 writes r5=0x22 in the same cycle -> r5 reads 0x22 afterward; wr_collide=1 for one cycle.
REQ-039 Write r7=0xDEAD while rd_addr0=7 in the same cycle -> rd_data0=0xDEAD combinationally; a write to r0=0xFF -> r0 reads 0 and wr_collide stays 0.
REQ-040 rsv r9 -> rd_pend=1 on the next cycles; write r9 -> rd_pend=0 in the write cycle (bypass mask) and after; rsv and write r9 in the same cycle -> pend stays 1.
REQ-041 rst asserted at clr_idx=10 of the clear sequence -> busy stays high for 32 cycles after release; all pending bits are 0.
REQ-042 Rebuild with BYPASS=0: write r3=0x5 with rd_addr0=3 in the same cycle -> old value seen; 0x5 seen next cycle.
